// File: rtl/adaptive_integration_sequencer.sv
// adaptive_integration_sequencer
// Purpose : picks the radar integration mode (CPI length) from J/S samples,
//           applying thresholds, downward hysteresis, a dwell filter and a
//           track-load mode cap, then hands the new mode to the waveform
//           generator at a CPI boundary through a valid/ready offer.
// Ports   : clk, rst_n (async, active-low)
//           js_valid/js_db            - J/S sample stream
//           cfg_thr/cfg_hyst/cfg_dwell/cfg_mode_cap/cfg_auto_en/
//           cfg_manual_mode           - static-ish configuration
//           cpi_end                   - CPI boundary pulse
//           wf_valid/wf_ready/wf_mode - mode offer handshake (wf_mode shows
//                                       the current mode outside an offer)
//           transition_busy           - sequencer not idle
//           transitions_count/jam_cycles - statistics
// Options : define AIS_STATS_EN to build the statistics counters; without it
//           transitions_count and jam_cycles are tied to zero.
// Timing  : offer appears the cycle after cpi_end; offer is held until
//           wf_ready, then one further CPI of holdoff.

module adaptive_integration_sequencer #(
  parameter int NUM_MODES = 4,
  parameter int JS_W      = 8,
  parameter int DWELL_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          js_valid,
  input  logic [JS_W-1:0]               js_db,
  input  logic [JS_W*(NUM_MODES-1)-1:0] cfg_thr,
  input  logic [JS_W-1:0]               cfg_hyst,
  input  logic [DWELL_W-1:0]            cfg_dwell,
  input  logic [2:0]                    cfg_mode_cap,
  input  logic                          cfg_auto_en,
  input  logic [2:0]                    cfg_manual_mode,
  input  logic                          cpi_end,
  input  logic                          wf_ready,
  output logic                          wf_valid,
  output logic [2:0]                    wf_mode,
  output logic                          transition_busy,
  output logic [31:0]                   transitions_count,
  output logic [31:0]                   jam_cycles
);

  localparam logic [2:0]         MAX_MODE  = 3'(NUM_MODES - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUALIFY,
    S_WAIT_CPI,
    S_OFFER,
    S_HOLDOFF
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         cur_q,   cur_d;
  logic [2:0]         pend_q,  pend_d;
  logic [2:0]         qtgt_q,  qtgt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  // ---------------------------------------------------------------------------
  // Target mode computation
  // ---------------------------------------------------------------------------
  logic [2:0]      cap_eff;
  logic [2:0]      man_tgt;
  logic [2:0]      raw_tgt;
  logic [2:0]      auto_tgt;
  logic [3:0]      up_cnt;
  logic [JS_W-1:0] thr_cur;
  logic [JS_W-1:0] thr_dn;

  always_comb begin
    cap_eff  = (cfg_mode_cap > MAX_MODE) ? MAX_MODE : cfg_mode_cap;
    // cap_eff never exceeds MAX_MODE, so one clip covers both limits
    man_tgt  = (cfg_manual_mode > cap_eff) ? cap_eff : cfg_manual_mode;
    up_cnt   = '0;
    thr_cur  = '0;
    for (int k = 0; k < NUM_MODES - 1; k++) begin
      if (js_db >= cfg_thr[k*JS_W +: JS_W]) up_cnt = up_cnt + 4'd1;
      // entry threshold of the current mode, used for the hysteresis test
      if (cur_q == 3'(k + 1)) thr_cur = cfg_thr[k*JS_W +: JS_W];
    end
    raw_tgt  = (up_cnt > {1'b0, cap_eff}) ? cap_eff : up_cnt[2:0];
    thr_dn   = (thr_cur > cfg_hyst) ? (thr_cur - cfg_hyst) : '0;
    auto_tgt = raw_tgt;
    if (raw_tgt < cur_q) begin
      // downward moves are one step at a time, and only once J/S has fallen
      // clearly below the current mode's entry threshold
      auto_tgt = (js_db < thr_dn) ? (cur_q - 3'd1) : cur_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Cap override: the cap must win over any sample-driven activity, but must
  // not keep re-triggering once the pending mode already equals the cap, and
  // a handshake already completing in OFFER is allowed to finish first.
  // ---------------------------------------------------------------------------
  logic pend_live;
  logic cap_ovr;

  always_comb begin
    pend_live = (state_q == S_WAIT_CPI) || (state_q == S_OFFER);
    cap_ovr   = ((cap_eff < cur_q) || (pend_live && (pend_q > cap_eff))) &&
                !(pend_live && (pend_q == cap_eff)) &&
                !((state_q == S_OFFER) && wf_ready);
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic [DWELL_W-1:0] dwell_inc;

  always_comb begin
    dwell_inc = (dwell_q == '1) ? dwell_q : (dwell_q + DWELL_ONE);

    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    qtgt_d  = qtgt_q;
    dwell_d = dwell_q;

    if (cap_ovr) begin
      state_d = S_WAIT_CPI;
      pend_d  = cap_eff;
      dwell_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!cfg_auto_en) begin
            if (man_tgt != cur_q) begin
              state_d = S_WAIT_CPI;
              pend_d  = man_tgt;
            end
          end else if (js_valid && (auto_tgt != cur_q)) begin
            dwell_d = DWELL_ONE;
            qtgt_d  = auto_tgt;
            // a dwell setting of 0 or 1 is satisfied by this first sample
            if (DWELL_ONE >= cfg_dwell) begin
              state_d = S_WAIT_CPI;
              pend_d  = auto_tgt;
            end else begin
              state_d = S_QUALIFY;
            end
          end
        end

        S_QUALIFY: begin
          if (!cfg_auto_en) begin
            state_d = S_IDLE;
            dwell_d = '0;
          end else if (js_valid) begin
            if (auto_tgt == qtgt_q) begin
              dwell_d = dwell_inc;
              if (dwell_inc >= cfg_dwell) begin
                state_d = S_WAIT_CPI;
                pend_d  = qtgt_q;
              end
            end else begin
              state_d = S_IDLE;
              dwell_d = '0;
            end
          end
        end

        S_WAIT_CPI: begin
          if (cpi_end) state_d = S_OFFER;
        end

        S_OFFER: begin
          // a coincident cpi_end is consumed by the handshake, so holdoff
          // always waits for the following boundary
          if (wf_ready) begin
            cur_d   = pend_q;
            state_d = S_HOLDOFF;
          end
        end

        S_HOLDOFF: begin
          if (cpi_end) begin
            state_d = S_IDLE;
            dwell_d = '0;
          end
        end

        default: begin
          state_d = S_IDLE;
          dwell_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      pend_q  <= '0;
      qtgt_q  <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      qtgt_q  <= qtgt_d;
      dwell_q <= dwell_d;
    end
  end

  assign wf_valid        = (state_q == S_OFFER);
  assign wf_mode         = wf_valid ? pend_q : cur_q;
  assign transition_busy = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef AIS_STATS_EN
  logic [31:0] tcnt_q;
  logic [31:0] jam_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      jam_q  <= '0;
    end else begin
      if (wf_valid && wf_ready) tcnt_q <= tcnt_q + 32'd1;
      if ((cur_q != 3'd0) && (jam_q != 32'hFFFF_FFFF)) jam_q <= jam_q + 32'd1;
    end
  end

  assign transitions_count = tcnt_q;
  assign jam_cycles        = jam_q;
`else
  assign transitions_count = '0;
  assign jam_cycles        = '0;
`endif

endmodule

// File: tb/tb_adaptive_integration_sequencer.sv
// tb_adaptive_integration_sequencer
// Purpose : directed bench for adaptive_integration_sequencer with a
//           behavioural model of the mode-selection rules and a per-cycle
//           output comparison, plus literal expectations per scenario.
// Ports   : none (top-level bench).

module tb_adaptive_integration_sequencer;

`ifdef AIS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        js_valid;
  logic [7:0]  js_db;
  logic [23:0] cfg_thr;
  logic [7:0]  cfg_hyst;
  logic [15:0] cfg_dwell;
  logic [2:0]  cfg_mode_cap;
  logic        cfg_auto_en;
  logic [2:0]  cfg_manual_mode;
  logic        cpi_end;
  logic        wf_ready;
  logic        wf_valid;
  logic [2:0]  wf_mode;
  logic        transition_busy;
  logic [31:0] transitions_count;
  logic [31:0] jam_cycles;

  adaptive_integration_sequencer #(
    .NUM_MODES(4), .JS_W(8), .DWELL_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .js_valid(js_valid), .js_db(js_db),
    .cfg_thr(cfg_thr), .cfg_hyst(cfg_hyst), .cfg_dwell(cfg_dwell),
    .cfg_mode_cap(cfg_mode_cap), .cfg_auto_en(cfg_auto_en),
    .cfg_manual_mode(cfg_manual_mode),
    .cpi_end(cpi_end), .wf_ready(wf_ready),
    .wf_valid(wf_valid), .wf_mode(wf_mode),
    .transition_busy(transition_busy),
    .transitions_count(transitions_count), .jam_cycles(jam_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  // model state
  int          thr_tab[3];
  int          m_cur, m_pend, m_tgt, m_run;
  bit          m_wait, m_offer, m_hold;
  logic [31:0] m_count;
  logic [31:0] m_jam;
  bit          e_valid, e_busy;
  int          e_mode;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Mode the sample rules ask for, given the current mode and config.
  function automatic int tgt_auto(input int js);
    int t;
    int cap;
    int lim;
    t = 0;
    for (int k = 0; k < 3; k++) if (js >= thr_tab[k]) t++;
    cap = (int'(cfg_mode_cap) > 3) ? 3 : int'(cfg_mode_cap);
    if (t > cap) t = cap;
    if (t < m_cur) begin
      lim = thr_tab[m_cur-1] - int'(cfg_hyst);
      if (lim < 0) lim = 0;
      t = (js < lim) ? m_cur - 1 : m_cur;
    end
    return t;
  endfunction

  function automatic bit busy_now();
    return (m_run > 0) || m_wait || m_offer || m_hold;
  endfunction

  task automatic model_reset();
    m_cur = 0; m_pend = 0; m_tgt = 0; m_run = 0;
    m_wait = 0; m_offer = 0; m_hold = 0;
    m_count = '0; m_jam = '0;
    e_valid = 0; e_busy = 0; e_mode = 0;
  endtask

  // jam model: cycles spent outside mode 0
  always @(posedge clk) begin
    if (rst_n && (m_cur != 0) && (m_jam != 32'hFFFF_FFFF)) m_jam = m_jam + 32'd1;
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cmp_wf_valid", {31'd0, wf_valid}, {31'd0, e_valid});
      chk("cmp_wf_mode",  {29'd0, wf_mode}, 32'(e_mode));
      chk("cmp_busy",     {31'd0, transition_busy}, {31'd0, e_busy});
      chk("cmp_tcount",   transitions_count, STATS ? m_count : 32'd0);
      chk("cmp_jam",      jam_cycles, STATS ? m_jam : 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n samples of the same J/S value, with dwell tracking
  task automatic auto_run(input int js, input int n);
    int t;
    int need;
    for (int i = 0; i < n; i++) begin
      t = tgt_auto(js);
      js_db = 8'(js);
      js_valid = 1'b1;
      step();
      js_valid = 1'b0;
      if (!(m_wait || m_hold || m_offer)) begin
        if (m_run > 0 && t == m_tgt) m_run++;
        else if (m_run > 0) m_run = 0;
        else if (t != m_cur) begin
          m_run = 1;
          m_tgt = t;
        end
        need = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
        if (m_run > 0 && m_run >= need) begin
          m_wait = 1;
          m_pend = m_tgt;
          m_run = 0;
        end
      end
      e_busy = busy_now();
    end
  endtask

  task automatic cpi_pulse();
    cpi_end = 1'b1;
    step();
    cpi_end = 1'b0;
    if (m_wait) begin
      m_wait = 0;
      m_offer = 1;
      e_valid = 1;
      e_mode = m_pend;
    end else if (m_hold) begin
      m_hold = 0;
    end
    e_busy = busy_now();
  endtask

  task automatic commit(input bit with_cpi);
    wf_ready = 1'b1;
    cpi_end = with_cpi;
    step();
    wf_ready = 1'b0;
    cpi_end = 1'b0;
    m_cur = m_pend;
    m_count = m_count + 32'd1;
    m_offer = 0;
    m_hold = 1;
    e_valid = 0;
    e_mode = m_cur;
    e_busy = 1;
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    thr_tab[0] = 16; thr_tab[1] = 32; thr_tab[2] = 48;
    rst_n = 1'b0;
    js_valid = 1'b0; js_db = '0;
    cfg_thr = {8'd48, 8'd32, 8'd16};
    cfg_hyst = 8'd4; cfg_dwell = 16'd3; cfg_mode_cap = 3'd3;
    cfg_auto_en = 1'b1; cfg_manual_mode = 3'd0;
    cpi_end = 1'b0; wf_ready = 1'b0;
    model_reset();
    cmp_on = 1'b1;

    // reset state
    step(); step();
    chk("rst_valid", {31'd0, wf_valid}, 32'd0);
    chk("rst_mode", {29'd0, wf_mode}, 32'd0);
    chk("rst_busy", {31'd0, transition_busy}, 32'd0);
    chk("rst_tcount", transitions_count, 32'd0);
    chk("rst_jam", jam_cycles, 32'd0);
    rst_n = 1'b1;
    step();

    // manual request, reset in the middle of the offer
    cfg_auto_en = 1'b0; cfg_manual_mode = 3'd1;
    step();
    m_wait = 1; m_pend = 1; e_busy = 1;
    chk("man_busy", {31'd0, transition_busy}, 32'd1);
    cpi_pulse();
    chk("man_offer_mode", {29'd0, wf_mode}, 32'd1);
    for (int i = 0; i < 9; i++) step();
    #1;
    rst_n = 1'b0;
    cfg_manual_mode = 3'd0;
    model_reset();
    #1;
    chk("rst_mid_valid", {31'd0, wf_valid}, 32'd0);
    chk("rst_mid_tcount", transitions_count, 32'd0);
    chk("rst_mid_busy", {31'd0, transition_busy}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    cfg_auto_en = 1'b1;
    step();

    // 0 -> 2 after three samples of 40, offer held 20 cycles, commit with cpi_end
    auto_run(40, 3);
    chk("up_busy", {31'd0, transition_busy}, 32'd1);
    step(); step();
    cpi_pulse();
    chk("up_valid", {31'd0, wf_valid}, 32'd1);
    chk("up_mode", {29'd0, wf_mode}, 32'd2);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_valid", {31'd0, wf_valid}, 32'd1);
      chk("hold_mode", {29'd0, wf_mode}, 32'd2);
    end
    commit(1'b1);
    chk("up_tcount", transitions_count, STATS ? 32'd1 : 32'd0);
    step(); step(); step();
    chk("holdoff_busy", {31'd0, transition_busy}, 32'd1);
    cpi_pulse();
    chk("holdoff_exit", {31'd0, transition_busy}, 32'd0);

    // hysteresis: 30 keeps mode 2, 27 steps down to 1
    auto_run(30, 3);
    chk("hyst_hold", {31'd0, transition_busy}, 32'd0);
    auto_run(27, 3);
    cpi_pulse();
    chk("down_mode", {29'd0, wf_mode}, 32'd1);
    commit(1'b0);
    auto_run(60, 2);
    chk("holdoff_ignore", {31'd0, transition_busy}, 32'd1);
    cpi_pulse();

    // broken dwell returns to idle
    auto_run(40, 2);
    chk("dwell_busy", {31'd0, transition_busy}, 32'd1);
    auto_run(10, 1);
    chk("dwell_abort", {31'd0, transition_busy}, 32'd0);
    cpi_pulse();
    chk("dwell_novalid", {31'd0, wf_valid}, 32'd0);

    // cap override from mode 3
    auto_run(60, 3);
    cpi_pulse();
    commit(1'b0);
    cpi_pulse();
    chk("cap_pre_mode", {29'd0, wf_mode}, 32'd3);
    cfg_mode_cap = 3'd1;
    step();
    m_wait = 1; m_pend = 1; m_run = 0; e_busy = 1;
    auto_run(60, 2);
    cpi_pulse();
    chk("cap_mode", {29'd0, wf_mode}, 32'd1);
    commit(1'b0);
    cpi_pulse();
    auto_run(60, 2);
    chk("cap_clip", {31'd0, transition_busy}, 32'd0);

    // dwell 0, out-of-range cap, single-step down, saturated hysteresis
    cfg_mode_cap = 3'd7; cfg_dwell = 16'd0;
    auto_run(50, 1);
    chk("dwell0_busy", {31'd0, transition_busy}, 32'd1);
    cpi_pulse();
    chk("dwell0_mode", {29'd0, wf_mode}, 32'd3);
    commit(1'b0);
    cpi_pulse();
    cfg_dwell = 16'd1;
    auto_run(20, 1);
    cpi_pulse();
    chk("single_step", {29'd0, wf_mode}, 32'd2);
    commit(1'b0);
    cpi_pulse();
    cfg_hyst = 8'd40;
    auto_run(0, 2);
    chk("hyst_sat", {31'd0, transition_busy}, 32'd0);
    step(); step();

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adaptive_integration_sequencer.md
ADAPTIVE_INTEGRATION_SEQUENCER -- requirements
Module: adaptive_integration_sequencer

Interface
REQ-001 SHALL have parameter NUM_MODES, default 4, number of integration modes (2..8); mode 0 = baseline, higher = longer CPI.
REQ-002 SHALL have parameter JS_W, default 8, J/S sample width (dB x4, unsigned).
REQ-003 SHALL have parameter DWELL_W, default 16, dwell counter width.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port js_valid  in  1  new J/S sample strobe.
REQ-007 SHALL have port js_db  in  JS_W  J/S sample.
REQ-008 SHALL have port cfg_thr  in  JS_W*(NUM_MODES-1)  up-thresholds; slice k = entry threshold of mode k+1; ascending.
REQ-009 SHALL have port cfg_hyst  in  JS_W  down-hysteresis.
REQ-010 SHALL have port cfg_dwell  in  DWELL_W  consecutive qualifying samples required.
REQ-011 SHALL have port cfg_mode_cap  in  3  highest permitted mode (track-load limit).
REQ-012 SHALL have port cfg_auto_en  in  1  1 = automatic, 0 = manual.
REQ-013 SHALL have port cfg_manual_mode  in  3  forced mode.
REQ-014 SHALL have port cpi_end  in  1  one-cycle pulse from waveform generator at CPI boundary.
REQ-015 SHALL have port wf_ready  in  1  waveform generator accepts new mode.
REQ-016 SHALL have port wf_valid  out  1  new mode offered.
REQ-017 SHALL have port wf_mode  out  3  offered/current mode.
REQ-018 SHALL have port transition_busy  out  1  high in any state other than IDLE.
REQ-019 SHALL have port transitions_count  out  32  committed transitions.
REQ-020 SHALL have port jam_cycles  out  32  cycles spent in mode != 0.

Function
REQ-021 SHALL compute target = count of k with js_db >= thr[k], clipped to min(cfg_mode_cap, NUM_MODES-1); out-of-range cap/manual values clip to NUM_MODES-1.
REQ-022 SHALL apply hysteresis downward: when target < current, lower target only if js_db < thr[current-1] - cfg_hyst (saturate at 0), else target = current; step down at most one mode per transition; up jumps directly to target.
REQ-023 SHALL use FSM IDLE -> QUALIFY -> WAIT_CPI -> OFFER -> HOLDOFF -> IDLE.
REQ-024 SHALL in IDLE enter QUALIFY on js_valid with target != current; dwell counter loads 1.
REQ-025 SHALL in QUALIFY increment dwell on each js_valid with the same target; different target (incl. current) returns to IDLE; dwell >= cfg_dwell enters WAIT_CPI; cfg_dwell 0 or 1 enters WAIT_CPI on the first sample.
REQ-026 SHALL in WAIT_CPI latch pending mode and enter OFFER the cycle after cpi_end; cpi_end in other states is ignored.
REQ-027 SHALL in OFFER hold wf_valid=1, wf_mode=pending stable until wf_ready; on wf_valid & wf_ready: current <= pending, transitions_count +1 (wrap at 2^32), enter HOLDOFF.
REQ-028 SHALL in HOLDOFF ignore samples for one full CPI (until next cpi_end), then IDLE.
REQ-029 SHALL with cfg_auto_en=0 skip QUALIFY: manual mode != current goes directly to WAIT_CPI; hysteresis and dwell bypassed.
REQ-030 SHALL when cfg_mode_cap drops below current in any state, abort pending and enter WAIT_CPI with pending = cap (cap override has priority over samples).
REQ-031 SHALL drive wf_mode = current outside OFFER; jam_cycles saturates at 2^32-1.
REQ-032 SHALL treat simultaneous cpi_end and wf_ready in OFFER as handshake only; cpi_end not counted for HOLDOFF.

Reset
REQ-033 SHALL on rst_n low asynchronously set FSM IDLE, current 0, dwell 0, wf_valid 0, wf_mode 0, transition_busy 0, counters 0.
REQ-034 SHALL on reset mid-OFFER drop wf_valid immediately, no count increment.

Configuration
REQ-035 SHALL compile transitions_count and jam_cycles logic only with AIS_STATS_EN defined; without it both outputs SHALL tie to 0, all other behaviour identical.

Verification
REQ-036 SHALL cover: NUM_MODES=4, thr={16,32,48}, dwell=3, 3 samples js=40 then cpi_end -> wf_valid with wf_mode=2 one cycle later; wf_ready -> count=1.
REQ-037 SHALL cover: current=2, hyst=4, samples js=30 -> no transition; samples js=27 x dwell then cpi_end -> wf_mode=1 (single step).
REQ-038 SHALL cover: js=40 x2 then js=10, dwell=3 -> return to IDLE, no wf_valid.
REQ-039 SHALL cover: current=3, cfg_mode_cap=1 -> after next cpi_end wf_mode=1 regardless of js=60.
REQ-040 SHALL cover: wf_ready low for 20 cycles in OFFER -> wf_valid and wf_mode stable 20 cycles; rst_n pulse at cycle 10 -> wf_valid 0, count unchanged.
